// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg -- constants and types shared by the UART transmit arbiter.
//   state_t   : arbiter FSM states (IDLE, SEND, WAIT)
//   N_REQ_DEF : default number of byte requesters
//   BYTE_W    : width of one transmitted byte
package uart_tx_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if -- requester-side and transmitter-side signals of the arbiter.
//   req      : per-requester byte-pending flag          (master -> slave)
//   req_data : byte i on [8i+7:8i]                      (master -> slave)
//   lock     : requester i keeps the grant after a byte (master -> slave)
//   tx_done  : end-of-frame pulse from the transmitter  (master -> slave)
//   ack      : one-cycle pulse when byte i is consumed  (slave -> master)
//   tx_de    : one-cycle start strobe to the transmitter(slave -> master)
//   tx_data  : byte to transmit, valid with tx_de       (slave -> master)
//   gnt      : one-hot current owner, zero when idle    (slave -> master)
//   err      : one-cycle watchdog timeout pulse         (slave -> master)
//
// Handshakes: req[i] acts as valid and ack[i] as the accept; requester i holds
// req[i] and its byte stable until it sees ack[i], and may drop req[i] before
// being granted. ack[i] is always coincident with tx_de, and tx_data is valid
// on that same cycle. tx_done closes the frame started by tx_de and is only
// looked at while the arbiter is waiting for it.
interface uart_tx_arb_if
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
);
    logic [N_REQ-1:0]        req;
    logic [BYTE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ-1:0]        ack;
    logic                    tx_de;
    logic [BYTE_W-1:0]       tx_data;
    logic                    tx_done;
    logic [N_REQ-1:0]        gnt;
    logic                    err;

    modport slave (
        input  req, req_data, lock, tx_done,
        output ack, tx_de, tx_data, gnt, err
    );

    modport master (
        output req, req_data, lock, tx_done,
        input  ack, tx_de, tx_data, gnt, err
    );
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick -- combinational round-robin picker.
//   req        : request vector
//   last_grant : index of the most recent owner; the search starts one above it
//   onehot     : one-hot winner (zero if no request)
//   idx        : winner index
//   any        : at least one request is pending
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        // Walk last_grant+1 .. last_grant+N_REQ (mod N_REQ); the first hit wins.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % N_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- round-robin arbiter feeding bytes from N_REQ requesters into
// one UART transmitter.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : uart_tx_arb_if.slave (req/req_data/lock/tx_done in,
//               ack/tx_de/tx_data/gnt/err out)
//   state_dbg : current FSM state
// Optional: define UART_TX_ARB_TIMEOUT_EN to enable the WAIT watchdog
// (err pulse after TIMEOUT_CYC cycles without tx_done); otherwise err is 0
// and WAIT waits indefinitely.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_arb_if.slave   bus,
    output state_t         state_dbg
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arb: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_tx_arb: TIMEOUT_CYC must be at least 1");
    end

    state_t              state;
    logic [IW-1:0]       last_grant;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    ack_q;
    logic                tx_de_q;
    logic [BYTE_W-1:0]   tx_data_q;

    logic [N_REQ-1:0]    pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                keep_owner;

    function automatic logic [BYTE_W-1:0] byte_of(input logic [BYTE_W*N_REQ-1:0] d,
                                                  input logic [IW-1:0] i);
        logic [BYTE_W-1:0] r;
        r = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (IW'(j) == i) r = d[BYTE_W*j +: BYTE_W];
        end
        return r;
    endfunction

    uart_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req        (bus.req),
        .last_grant (last_grant),
        .onehot     (pick_oh),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // While an owner holds the grant, last_grant already equals its index.
    assign keep_owner = bus.lock[last_grant] & bus.req[last_grant];

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wd_cnt;
    logic          wd_expire;
    logic          err_q;
    // wd_cnt equals the number of cycles since tx_de, so err lands exactly
    // TIMEOUT_CYC cycles after the start strobe.
    assign wd_expire = (wd_cnt == CW'(TIMEOUT_CYC - 1));
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            gnt_q      <= '0;
            ack_q      <= '0;
            tx_de_q    <= 1'b0;
            tx_data_q  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            tx_de_q <= 1'b0;
            ack_q   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state      <= SEND;
                        gnt_q      <= pick_oh;
                        ack_q      <= pick_oh;
                        tx_de_q    <= 1'b1;
                        tx_data_q  <= byte_of(bus.req_data, pick_idx);
                        last_grant <= pick_idx;
                    end
                end
                SEND: begin
                    state <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wd_cnt <= CW'(1);
`endif
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        if (keep_owner) begin
                            // Locked owner goes again; priority does not rotate.
                            state     <= SEND;
                            ack_q     <= gnt_q;
                            tx_de_q   <= 1'b1;
                            tx_data_q <= byte_of(bus.req_data, last_grant);
                        end else if (pick_any) begin
                            state      <= SEND;
                            gnt_q      <= pick_oh;
                            ack_q      <= pick_oh;
                            tx_de_q    <= 1'b1;
                            tx_data_q  <= byte_of(bus.req_data, pick_idx);
                            last_grant <= pick_idx;
                        end else begin
                            state <= IDLE;
                            gnt_q <= '0;
                        end
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wd_expire) begin
                        // last_grant already names the timed-out owner.
                        err_q <= 1'b1;
                        state <= IDLE;
                        gnt_q <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.tx_de   = tx_de_q;
    assign bus.tx_data = tx_data_q;
    assign state_dbg   = state;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100000, meaning the maximum clk cycles from tx_de to tx_done.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, N_REQ bits: per-requester byte-pending flag.
REQ-006 The block SHALL have port req_data, input, 8*N_REQ bits: byte i on [8i+7:8i].
REQ-007 The block SHALL have port lock, input, N_REQ bits: when high, requester i keeps the grant after its byte completes.
REQ-008 The block SHALL have port ack, output, N_REQ bits: one-cycle pulse when byte i is consumed.
REQ-009 The block SHALL have port tx_de, output, 1 bit: one-cycle start strobe to the UART transmitter.
REQ-010 The block SHALL have port tx_data, output, 8 bits: byte to transmit, valid while tx_de is high.
REQ-011 The block SHALL have port tx_done, input, 1 bit: one-cycle pulse from the transmitter at end of frame.
REQ-012 The block SHALL have port gnt, output, N_REQ bits: one-hot current owner, all-zero when idle.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse on timeout (see REQ-026).

Function
REQ-014 The block SHALL implement states IDLE, SEND and WAIT, with all outputs registered.
REQ-015 In IDLE with any req bit high in cycle N, the block SHALL select a winner round-robin and, in cycle N+1, be in SEND with gnt, tx_de, tx_data and ack for that winner.
REQ-016 Round-robin search SHALL start at (last_grant+1) mod N_REQ; after reset last_grant SHALL be N_REQ-1, so index 0 has first priority.
REQ-017 SEND SHALL last exactly one cycle: tx_de=1, tx_data=req_data[winner], ack[winner]=1, with ack and tx_de coincident; next state WAIT.
REQ-018 In WAIT, tx_de and ack SHALL be 0, gnt SHALL hold, and tx_data SHALL hold its last value.
REQ-019 On tx_done in WAIT with lock[g]=1 and req[g]=1, the block SHALL re-enter SEND next cycle for the same g without rotating priority.
REQ-020 On tx_done in WAIT otherwise, if any req is high, the block SHALL arbitrate and enter SEND next cycle; if none is high, it SHALL enter IDLE with gnt=0.
REQ-021 tx_done SHALL be ignored in IDLE and SEND.
REQ-022 Requester i SHALL hold req[i] and its byte stable until ack[i]; deasserting req before grant SHALL be legal, with no ack and no transmission.
REQ-023 Changes to req or lock during WAIT SHALL only take effect at the tx_done decision point.
REQ-024 A requester SHALL never receive ack without a matching tx_de.

Reset
REQ-025 rst SHALL force state=IDLE, tx_de=0, tx_data=0, ack=0, gnt=0, err=0 and last_grant=N_REQ-1 on the next edge, including mid-WAIT; the in-flight byte is abandoned and no ack is reissued.

Configuration
REQ-026 With UART_TX_ARB_TIMEOUT_EN defined, a watchdog counter SHALL start in SEND and count in WAIT; when it reaches TIMEOUT_CYC without tx_done, the block SHALL pulse err for 1 cycle, go to IDLE with gnt=0, and advance last_grant to the timed-out owner.
REQ-027 Without UART_TX_ARB_TIMEOUT_EN, there SHALL be no counter, err SHALL be tied 0, and WAIT SHALL wait indefinitely.

Structure
REQ-028 Shared package uart_tx_arb_pkg SHALL hold the state enumeration, the default N_REQ and the byte-width constant (8).
REQ-029 Winner selection SHALL be the sub-module uart_rr_pick, a combinational round-robin picker (req, last_grant -> one-hot, index, any).

Verification
REQ-030 Reset, then req=0001 with byte 0x55: next cycle tx_de=1, tx_data=0x55, ack=0001, gnt=0001; tx_done 20 cycles later -> IDLE with gnt=0.
REQ-031 req=1111 held, bytes 0xA0..0xA3, lock=0: grant order 0,1,2,3,0, each SEND one cycle after the prior tx_done.
REQ-032 lock=0010, req=0110: three consecutive bytes go to requester 1 with no requester 2 grant until lock[1] drops; then requester 2 is granted.
REQ-033 Assert rst in WAIT owned by requester 2: all outputs 0 next cycle; a later req=0100 is granted from IDLE normally.
REQ-034 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=50, no tx_done: err pulses exactly once 50 cycles after tx_de, then IDLE; with req=0011 pending, requester 1 is granted next.
REQ-035 tx_done pulsed during IDLE and during SEND: no state change and no extra tx_de.
